// File: rtl/draw_obj_fall_ctl.sv
// draw_obj_fall_ctl: mouse-follow / click-to-drop gravity position controller, floor rebound when DRAW_OBJ_BOUNCE_EN is defined
module draw_obj_fall_ctl #(
  parameter int XY_W     = 12,
  parameter int SCREEN_H = 600,
  parameter int OBJ_H    = 64,
  parameter int TICK_DIV = 650000,
  parameter int ACCEL    = 1,
  parameter int V_MAX    = 16
`ifdef DRAW_OBJ_BOUNCE_EN
  ,
  parameter int V_MIN    = 2,
  parameter int DAMP_SH  = 1
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mouse_left,
  input  logic            mouse_right,
  input  logic [XY_W-1:0] mouse_xpos,
  input  logic [XY_W-1:0] mouse_ypos,
  output logic [XY_W-1:0] xpos,
  output logic [XY_W-1:0] ypos,
  output logic            falling,
  output logic            at_floor
);
  localparam int VW = $clog2(V_MAX + 1);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [XY_W-1:0] FLOOR_Y = XY_W'(SCREEN_H - OBJ_H);
  typedef enum logic [1:0] {FOLLOW, FALL, RISE, REST} state_t;
  state_t state_q, state_d;
  logic [XY_W-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic [VW-1:0] vel_q, vel_d, nv;
  logic [VW:0] inc;
  logic [XY_W:0] sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic left_q, right_q, falling_q, at_floor_q, l_edge, r_edge, tick, hit;
`ifdef DRAW_OBJ_BOUNCE_EN
  logic [VW-1:0] vr;
`endif
  assign xpos = xpos_q;
  assign ypos = ypos_q;
  assign falling = falling_q;
  assign at_floor = at_floor_q;
  always_comb begin
    l_edge = mouse_left & ~left_q;
    r_edge = mouse_right & ~right_q;
    tick = cnt_q == CW'(TICK_DIV - 1);
    inc = {1'b0, vel_q} + (VW+1)'(ACCEL);
    nv = inc > (VW+1)'(V_MAX) ? VW'(V_MAX) : inc[VW-1:0];
    sum = {1'b0, ypos_q} + (XY_W+1)'(nv);
    hit = sum >= {1'b0, FLOOR_Y};
`ifdef DRAW_OBJ_BOUNCE_EN
    vr = nv - (nv >> DAMP_SH);
`endif
    state_d = state_q;
    xpos_d = xpos_q;
    ypos_d = ypos_q;
    vel_d = vel_q;
    case (state_q)
      FOLLOW: if (l_edge && !r_edge) begin
        state_d = FALL;
        vel_d = '0;
      end else begin
        xpos_d = mouse_xpos;
        ypos_d = mouse_ypos > FLOOR_Y ? FLOOR_Y : mouse_ypos;
      end
      FALL: if (tick) begin
        vel_d = nv;
        ypos_d = hit ? FLOOR_Y : sum[XY_W-1:0];
        if (hit) begin
`ifdef DRAW_OBJ_BOUNCE_EN
          state_d = vr < VW'(V_MIN) ? REST : RISE;
          vel_d = vr < VW'(V_MIN) ? '0 : vr;
`else
          state_d = REST;
          vel_d = '0;
`endif
        end
      end
`ifdef DRAW_OBJ_BOUNCE_EN
      RISE: if (tick) begin
        if (XY_W'(vel_q) > ypos_q) begin
          ypos_d = '0;
          vel_d = '0;
          state_d = FALL;
        end else begin
          ypos_d = ypos_q - XY_W'(vel_q);
          vel_d = vel_q <= VW'(ACCEL) ? '0 : vel_q - VW'(ACCEL);
          state_d = vel_q <= VW'(ACCEL) ? FALL : RISE;
        end
      end
`endif
      REST: begin
        ypos_d = FLOOR_Y;
        vel_d = '0;
      end
      default: state_d = FOLLOW;
    endcase
    if (r_edge) begin
      state_d = FOLLOW;
      vel_d = '0;
    end
    cnt_d = (state_d != state_q || tick) ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= FOLLOW;
      xpos_q <= '0;
      ypos_q <= '0;
      vel_q <= '0;
      cnt_q <= '0;
      left_q <= 1'b0;
      right_q <= 1'b0;
      falling_q <= 1'b0;
      at_floor_q <= 1'b0;
    end else begin
      state_q <= state_d;
      xpos_q <= xpos_d;
      ypos_q <= ypos_d;
      vel_q <= vel_d;
      cnt_q <= cnt_d;
      left_q <= mouse_left;
      right_q <= mouse_right;
      falling_q <= state_d == FALL || state_d == RISE;
      at_floor_q <= state_d == REST;
    end
endmodule

// File: tb/tb_draw_obj_fall_ctl.sv
// tb_draw_obj_fall_ctl: directed checks of follow, drop, gravity fall, rest, right-click return and async reset
module tb_draw_obj_fall_ctl;
  logic clk = 1'b0, rst = 1'b0, mouse_left = 1'b0, mouse_right = 1'b0;
  logic [11:0] mouse_xpos = '0, mouse_ypos = '0, xpos, ypos;
  logic falling, at_floor;
  int n_chk = 0, n_fail = 0;
`ifdef DRAW_OBJ_BOUNCE_EN
  localparam int LAST_T = 69;
`else
  localparam int LAST_T = 41;
`endif
  draw_obj_fall_ctl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .mouse_left(mouse_left), .mouse_right(mouse_right),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .xpos(xpos), .ypos(ypos), .falling(falling), .at_floor(at_floor)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    clks(2);
    chk("rst_x", int'(xpos), 0);
    chk("rst_y", int'(ypos), 0);
    chk("rst_falling", int'(falling), 0);
    chk("rst_at_floor", int'(at_floor), 0);
    rst = 1'b1;
    mouse_xpos = 300;
    mouse_ypos = 200;
    clks(2);
    chk("follow_x", int'(xpos), 300);
    chk("follow_y", int'(ypos), 200);
    mouse_ypos = 700;
    clks(1);
    chk("clamp_y", int'(ypos), 536);
    chk("clamp_x", int'(xpos), 300);
    mouse_xpos = 100;
    mouse_ypos = 0;
    clks(2);
    chk("pre_drop_y", int'(ypos), 0);
    mouse_left = 1'b1;
    clks(1);
    mouse_left = 1'b0;
    chk("drop_falling", int'(falling), 1);
    for (int t = 1; t <= LAST_T; t++) begin
      clks(4);
      if (t == 1) chk("tick1_y", int'(ypos), 1);
      if (t == 2) chk("tick2_y", int'(ypos), 3);
      if (t == 3) chk("tick3_y", int'(ypos), 6);
      if (t == 5) mouse_xpos = 400;
      if (t == 10) mouse_left = 1'b1;
      if (t == 11) mouse_left = 1'b0;
      if (t == 16) chk("tick16_y", int'(ypos), 136);
      if (t == 17) chk("tick17_y_vmax", int'(ypos), 152);
      if (t == 40) chk("tick40_y", int'(ypos), 520);
      if (t == 40) chk("tick40_at_floor", int'(at_floor), 0);
      if (t == 41) chk("tick41_y", int'(ypos), 536);
      if (t == 41) chk("fall_x_frozen", int'(xpos), 100);
`ifdef DRAW_OBJ_BOUNCE_EN
      if (t == 41) chk("hit1_falling", int'(falling), 1);
      if (t == 42) chk("rise_y", int'(ypos), 528);
      if (t == 49) chk("apex1_y", int'(ypos), 500);
      if (t == 57) chk("hit2_y", int'(ypos), 536);
      if (t == 61) chk("apex2_y", int'(ypos), 526);
      if (t == 68) chk("pre_rest_at_floor", int'(at_floor), 0);
`endif
    end
    chk("rest_at_floor", int'(at_floor), 1);
    chk("rest_falling", int'(falling), 0);
    chk("rest_y", int'(ypos), 536);
    mouse_left = 1'b1;
    clks(2);
    mouse_left = 1'b0;
    clks(6);
    chk("rest_left_ignored_at_floor", int'(at_floor), 1);
    chk("rest_left_ignored_falling", int'(falling), 0);
    chk("rest_left_ignored_y", int'(ypos), 536);
    mouse_xpos = 50;
    mouse_ypos = 123;
    mouse_right = 1'b1;
    clks(1);
    mouse_right = 1'b0;
    chk("right_at_floor", int'(at_floor), 0);
    clks(1);
    chk("right_follow_y", int'(ypos), 123);
    chk("right_follow_x", int'(xpos), 50);
    mouse_left = 1'b1;
    mouse_right = 1'b1;
    clks(1);
    mouse_left = 1'b0;
    mouse_right = 1'b0;
    chk("both_falling", int'(falling), 0);
    mouse_ypos = 77;
    clks(6);
    chk("both_stay_falling", int'(falling), 0);
    chk("both_track_y", int'(ypos), 77);
    mouse_left = 1'b1;
    clks(1);
    mouse_left = 1'b0;
    mouse_xpos = 300;
    mouse_ypos = 200;
    clks(10);
    chk("midfall_falling", int'(falling), 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_x", int'(xpos), 0);
    chk("midrst_y", int'(ypos), 0);
    chk("midrst_falling", int'(falling), 0);
    chk("midrst_at_floor", int'(at_floor), 0);
    clks(1);
    rst = 1'b1;
    clks(2);
    chk("post_rst_x", int'(xpos), 300);
    chk("post_rst_y", int'(ypos), 200);
    chk("post_rst_falling", int'(falling), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
